// File: rtl/l2d_acc_sched_if.sv
// l2d_acc_sched_if: requester handshakes, write gating and array-side pins of the L2 data sub-bank scheduler.
interface l2d_acc_sched_if #(parameter int TAG_W = 6);
   logic             fl_req;
   logic [1:0]       fl_way;
   logic [9:0]       fl_set;
   logic             fl_gnt;
   logic             st_req;
   logic [1:0]       st_way;
   logic [9:0]       st_set;
   logic [3:0]       st_word_en;
   logic             st_gnt;
   logic             ld_req;
   logic [1:0]       ld_way;
   logic [9:0]       ld_set;
   logic [TAG_W-1:0] ld_tag;
   logic             ld_gnt;
   logic             write_dis;
   logic [1:0]       way_sel_l;
   logic [9:0]       set_l;
   logic [3:0]       word_en_l;
   logic             wr_en_l;
   logic             col_offset_l;
   logic [1:0]       wr_dsel;
   logic             rd_vld;
   logic [TAG_W-1:0] rd_tag;
   logic             way_err;
   logic             busy;
   modport master (
      output fl_req, fl_way, fl_set, st_req, st_way, st_set, st_word_en,
             ld_req, ld_way, ld_set, ld_tag, write_dis,
      input  fl_gnt, st_gnt, ld_gnt, way_sel_l, set_l, word_en_l, wr_en_l,
             col_offset_l, wr_dsel, rd_vld, rd_tag, way_err, busy
   );
   modport slave (
      input  fl_req, fl_way, fl_set, st_req, st_way, st_set, st_word_en,
             ld_req, ld_way, ld_set, ld_tag, write_dis,
      output fl_gnt, st_gnt, ld_gnt, way_sel_l, set_l, word_en_l, wr_en_l,
             col_offset_l, wr_dsel, rd_vld, rd_tag, way_err, busy
   );
endinterface

// File: rtl/l2d_acc_sched.sv
// l2d_acc_sched: fill/store/load arbiter for the L2 data sub-bank, one access per two cycles, tagged read return.
module l2d_acc_sched #(
   parameter int TAG_W      = 6,
   parameter int STARVE_MAX = 4
) (
   input logic             rclk,
   input logic             rst,
   l2d_acc_sched_if.slave  bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   logic [0:0]       state;
   logic [3:0]       cnt;
   logic             open, fl_ok, st_ok, starve;
   logic             fl_win, st_win, ld_win, any, issue;
   logic [1:0]       g_way;
   logic [9:0]       g_set;
   logic             v1, v2;
   logic [TAG_W-1:0] t1, t2;
   always_comb begin
      open   = (state == IDLE) & ~rst;
      fl_ok  = bus.fl_req & ~bus.write_dis;
      st_ok  = bus.st_req & ~bus.write_dis;
      starve = bus.ld_req & (cnt == 4'(STARVE_MAX));
      fl_win = open & fl_ok & ~starve;
      st_win = open & st_ok & ~fl_ok & ~starve;
      ld_win = open & bus.ld_req & (starve | ~(fl_ok | st_ok));
      any    = fl_win | st_win | ld_win;
      g_way  = fl_win ? bus.fl_way : st_win ? bus.st_way : bus.ld_way;
      g_set  = fl_win ? bus.fl_set : st_win ? bus.st_set : bus.ld_set;
      // one-hot on two bits is exactly odd parity; 00/11 are rejected
      issue  = any & (^g_way);
   end
   assign bus.fl_gnt = fl_win;
   assign bus.st_gnt = st_win;
   assign bus.ld_gnt = ld_win;
   assign bus.busy   = (state == HOLD) | v1 | v2 | bus.rd_vld | ld_win;
   always_ff @(posedge rclk) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= 4'd0;
         bus.col_offset_l <= 1'b1;
         bus.way_sel_l    <= 2'b11;
         bus.set_l        <= 10'h3ff;
         bus.word_en_l    <= 4'hf;
         bus.wr_en_l      <= 1'b1;
         bus.wr_dsel      <= 2'b00;
         bus.way_err      <= 1'b0;
         v1               <= 1'b0;
         v2               <= 1'b0;
         t1               <= '0;
         t2               <= '0;
         bus.rd_vld       <= 1'b0;
         bus.rd_tag       <= '0;
      end else begin
         state            <= any ? HOLD : IDLE;
         cnt              <= (~bus.ld_req | ld_win) ? 4'd0 :
                             ((fl_win | st_win) && cnt != 4'(STARVE_MAX)) ? cnt + 4'd1 : cnt;
         bus.col_offset_l <= ~issue;
         bus.way_sel_l    <= issue ? ~g_way : 2'b11;
         bus.set_l        <= issue ? ~g_set : 10'h3ff;
         bus.word_en_l    <= (issue & st_win) ? ~bus.st_word_en : (issue & fl_win) ? 4'h0 : 4'hf;
         bus.wr_en_l      <= ~(issue & ~ld_win);
         bus.wr_dsel      <= issue ? {fl_win, st_win} : 2'b00;
         bus.way_err      <= any & ~(^g_way);
         // read data is held by the array two cycles after the access cycle
         v1               <= issue & ld_win;
         t1               <= bus.ld_tag;
         v2               <= v1;
         t2               <= t1;
         bus.rd_vld       <= v2;
         bus.rd_tag       <= v2 ? t2 : bus.rd_tag;
      end
   end
endmodule

// File: tb/tb_l2d_acc_sched.sv
// tb_l2d_acc_sched: randomized and directed stimulus against a cycle-stamped scoreboard of grants, issues and read returns.
module tb_l2d_acc_sched;
   localparam int SM = 4;
   typedef struct {int cyc; logic [31:0] v;} ev_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   l2d_acc_sched_if #(.TAG_W(6)) b();
   l2d_acc_sched #(.TAG_W(6), .STARVE_MAX(SM)) dut (.rclk(clk), .rst(rst), .bus(b));
   ev_t  gq[$], iq[$], rq[$];
   bit   busy_exp [0:8191];
   int   n_chk = 0, n_pass = 0, cyc = 0, next_ok = 0, skipped = 0;
   bit   mon_on = 0;
   bit   fr, sr, lr, wd, rs;
   logic [1:0] fw, sw, lw;
   logic [9:0] fs, ss, ls;
   logic [3:0] swe;
   logic [5:0] lt;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
   endtask

   task automatic miss(string nm, int c);
      n_chk++;
      $display("FAIL %s expected at cyc=%0d not seen (now %0d)", nm, c, cyc);
   endtask

   function automatic logic [1:0] rway();
      int r = $urandom_range(9);
      return r == 0 ? 2'b00 : r == 1 ? 2'b11 : (r % 2 == 1) ? 2'b01 : 2'b10;
   endfunction

   // reference: who should win this cycle and what the array must see next
   task automatic model();
      int g = 0;
      logic [1:0] w;
      logic [9:0] s;
      logic [3:0] we;
      logic wr;
      logic [1:0] ds;
      bit ok;
      if (!rs && cyc >= next_ok) begin
         if (lr && skipped >= SM) g = 3;
         else if (fr && !wd) g = 1;
         else if (sr && !wd) g = 2;
         else if (lr) g = 3;
      end
      if (rs) begin
         next_ok = cyc + 1;
         skipped = 0;
         while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
         while (iq.size() > 0 && iq[$].cyc > cyc) void'(iq.pop_back());
         while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
         for (int i = 1; i <= 4; i++) busy_exp[cyc+i] = 0;
         return;
      end
      if (!lr || g == 3) skipped = 0;
      else if (g != 0) skipped = (skipped + 1 > SM) ? SM : skipped + 1;
      if (g == 0) return;
      w  = g == 1 ? fw : g == 2 ? sw : lw;
      s  = g == 1 ? fs : g == 2 ? ss : ls;
      we = g == 1 ? 4'h0 : g == 2 ? ~swe : 4'hf;
      wr = (g == 3);
      ds = g == 1 ? 2'b10 : g == 2 ? 2'b01 : 2'b00;
      ok = (w == 2'b01 || w == 2'b10);
      gq.push_back('{cyc, 32'(3'b100 >> (g - 1))});
      iq.push_back('{cyc + 1, ok ? 32'({1'b0, ~w, ~s, we, wr, ds, 1'b0})
                                 : 32'({1'b1, 2'b11, 10'h3ff, 4'hf, 1'b1, 2'b00, 1'b1})});
      next_ok = cyc + 2;
      busy_exp[cyc+1] = 1;
      if (g == 3) begin
         busy_exp[cyc] = 1;
         if (ok) begin
            busy_exp[cyc+2] = 1;
            busy_exp[cyc+3] = 1;
            rq.push_back('{cyc + 3, 32'(lt)});
         end
      end
      if (g == 1) fr = 0;
      if (g == 2) sr = 0;
      if (g == 3) lr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      rst = rs;
      b.fl_req = fr; b.fl_way = fw; b.fl_set = fs;
      b.st_req = sr; b.st_way = sw; b.st_set = ss; b.st_word_en = swe;
      b.ld_req = lr; b.ld_way = lw; b.ld_set = ls; b.ld_tag = lt;
      b.write_dis = wd;
      model();
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         logic [2:0]  g;
         logic [31:0] pins;
         ev_t e;
         g    = {b.fl_gnt, b.st_gnt, b.ld_gnt};
         pins = 32'({b.col_offset_l, b.way_sel_l, b.set_l, b.word_en_l, b.wr_en_l, b.wr_dsel, b.way_err});
         while (gq.size() > 0 && gq[0].cyc < cyc) begin e = gq.pop_front(); miss("grant", e.cyc); end
         while (iq.size() > 0 && iq[0].cyc < cyc) begin e = iq.pop_front(); miss("issue", e.cyc); end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin e = rq.pop_front(); miss("rd_vld", e.cyc); end
         if (g != 3'b000) begin
            if (gq.size() > 0 && gq[0].cyc == cyc) begin e = gq.pop_front(); chk("grant", 32'(g), e.v); end
            else chk("grant_unexpected", 32'(g), 32'd0);
         end
         if (!b.col_offset_l || b.way_err) begin
            if (iq.size() > 0 && iq[0].cyc == cyc) begin e = iq.pop_front(); chk("issue", pins, e.v); end
            else chk("issue_unexpected", pins, 32'({1'b1, 2'b11, 10'h3ff, 4'hf, 1'b1, 2'b00, 1'b0}));
         end else begin
            chk("idle_pins", pins, 32'({1'b1, 2'b11, 10'h3ff, 4'hf, 1'b1, 2'b00, 1'b0}));
         end
         if (b.rd_vld) begin
            if (rq.size() > 0 && rq[0].cyc == cyc) begin e = rq.pop_front(); chk("rd_tag", 32'(b.rd_tag), e.v); end
            else chk("rd_vld_unexpected", 32'(b.rd_vld), 32'd0);
         end
         chk("busy", 32'(b.busy), 32'(busy_exp[cyc]));
      end
   end

   initial begin
      {fr, sr, lr, wd} = '0;
      {fw, sw, lw} = '0;
      {fs, ss, ls} = '0;
      swe = '0;
      lt = '0;
      rs = 1;
      step();
      step();
      rs = 0;
      step();
      mon_on = 1;
      chk("rd_tag_reset", 32'(b.rd_tag), 32'd0);
      step();
      // lone load
      lr = 1; lw = 2'b01; ls = 10'h155; lt = 6'h2a;
      repeat (6) step();
      // all three requesters at once
      fr = 1; fw = 2'b10; fs = 10'h0f0;
      sr = 1; sw = 2'b01; ss = 10'h30c; swe = 4'b1010;
      lr = 1; lw = 2'b10; ls = 10'h001; lt = 6'h11;
      repeat (10) step();
      // continuous fill starves load until the counter saturates
      lr = 1; lw = 2'b01; ls = 10'h2aa; lt = 6'h05;
      for (int i = 0; i < 20; i++) begin
         fr = 1; fw = (i % 2 == 0) ? 2'b01 : 2'b10; fs = 10'(i * 37);
         if (i == 10) begin lr = 1; lt = 6'h06; end
         step();
      end
      fr = 0;
      repeat (5) step();
      // write_dis blocks store, loads still flow
      wd = 1; sr = 1; sw = 2'b10; ss = 10'h123; swe = 4'b0110;
      for (int i = 0; i < 8; i++) begin
         lr = 1; lw = 2'b01; ls = 10'(i); lt = 6'(i + 8);
         step();
      end
      lr = 0;
      wd = 0;
      repeat (6) step();
      // invalid store way
      sr = 1; sw = 2'b11; ss = 10'h3c3; swe = 4'b1111;
      repeat (5) step();
      // reset lands one cycle after a load grant
      lr = 1; lw = 2'b10; ls = 10'h0aa; lt = 6'h3f;
      step();
      rs = 1;
      step();
      rs = 0;
      step();
      chk("rd_tag_after_reset", 32'(b.rd_tag), 32'd0);
      repeat (5) step();
      // random traffic
      repeat (3000) begin
         if (!fr && $urandom_range(3) == 0) begin fr = 1; fw = rway(); fs = 10'($urandom); end
         if (!sr && $urandom_range(3) == 0) begin sr = 1; sw = rway(); ss = 10'($urandom); swe = 4'($urandom); end
         if (!lr && $urandom_range(2) == 0) begin lr = 1; lw = rway(); ls = 10'($urandom); lt = 6'($urandom); end
         if ($urandom_range(15) == 0) wd = ~wd;
         rs = ($urandom_range(199) == 0);
         step();
      end
      {fr, sr, lr, wd, rs} = '0;
      repeat (8) step();
      chk("drain", 32'(gq.size() + iq.size() + rq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
